// File: rtl/tx_slot_scheduler.sv
// tx_slot_scheduler: round-robin sharing of one telemetry radio among requesters,
// with radio warm-up, per-slot timeout and a guard gap between grants.
module tx_slot_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WARMUP_CYCLES = 20,
  parameter int MAX_SLOT_CYCLES = 50,
  parameter int GAP_CYCLES = 2,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int M1 = WARMUP_CYCLES > MAX_SLOT_CYCLES ? WARMUP_CYCLES : MAX_SLOT_CYCLES,
  localparam int MX = M1 > GAP_CYCLES ? M1 : GAP_CYCLES,
  localparam int CW = $clog2(MX + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_id,
  output logic               radio_on,
  output logic               busy,
  output logic               timeout
);
  typedef enum logic [2:0] {IDLE, WARMUP, ARB, GRANT, GAP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] rr_last;
  logic [IW-1:0] sel;
  int idx;
  // Scan downwards so the candidate closest after rr_last is written last and wins.
  always_comb begin
    sel = '0;
    idx = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(rr_last) + i) % NUM_REQ;
      if (req[idx]) sel = IW'(idx);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rr_last <= IW'(NUM_REQ - 1);
      grant <= '0;
      grant_id <= '0;
      radio_on <= 1'b0;
      busy <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: if (tx_enable && |req) begin
          state <= WARMUP;
          radio_on <= 1'b1;
          busy <= 1'b1;
          cnt <= '0;
        end
        WARMUP: if (!tx_enable) begin
          state <= IDLE;
          radio_on <= 1'b0;
          busy <= 1'b0;
          cnt <= '0;
        end else if (cnt == CW'(WARMUP_CYCLES - 1)) begin
          state <= ARB;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        ARB: if (!tx_enable || req == '0) begin
          state <= IDLE;
          radio_on <= 1'b0;
          busy <= 1'b0;
          cnt <= '0;
        end else begin
          state <= GRANT;
          grant <= NUM_REQ'(1) << sel;
          grant_id <= sel;
          rr_last <= sel;
          cnt <= '0;
        end
        // done has priority over the timeout on the last slot cycle
        GRANT: if (done[grant_id]) begin
          state <= GAP;
          grant <= '0;
          cnt <= '0;
        end else if (cnt == CW'(MAX_SLOT_CYCLES - 1)) begin
          state <= GAP;
          grant <= '0;
          timeout <= 1'b1;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
          state <= ARB;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        default: begin
          state <= IDLE;
          grant <= '0;
          radio_on <= 1'b0;
          busy <= 1'b0;
          cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tx_slot_scheduler.sv
// tb_tx_slot_scheduler: scenario tasks plus randomized slots checked against a
// slot-level round-robin model (order, slot length, timeout, gap length).
module tb_tx_slot_scheduler;
  logic clk = 1'b0;
  logic reset;
  logic tx_enable;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic radio_on;
  logic busy;
  logic timeout;
  int tests = 0;
  int fails = 0;
  int model_last = 3;

  tx_slot_scheduler dut (
    .clk(clk), .reset(reset), .tx_enable(tx_enable), .req(req), .done(done),
    .grant(grant), .grant_id(grant_id), .radio_on(radio_on), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got time=%0t want completion", $time);
    $fatal(1, "watchdog");
  end

  function automatic int next_id(input logic [3:0] mask);
    for (int i = 1; i <= 4; i++) begin
      if (mask[(model_last + i) % 4]) return (model_last + i) % 4;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    tx_enable = 1'b0;
    req = '0;
    done = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_last = 3;
  endtask

  // Runs one slot: waits for grant, holds it d cycles before pulsing done (d > 50 means timeout).
  task automatic slot(input int id, input int d, input int exp_gap, input bit noise);
    int gap;
    int len;
    int exp_len;
    bit bad;
    logic [3:0] exp_g;
    exp_g = 4'(1 << id);
    gap = 0;
    while (grant == 4'b0 && gap < 300) begin
      gap++;
      @(negedge clk);
    end
    tests++;
    if (grant !== exp_g || grant_id !== 2'(id)) begin
      fails++;
      $display("FAIL slot_grant: got grant=%b id=%0d, want grant=%b id=%0d", grant, grant_id, exp_g, id);
      return;
    end
    if (exp_gap >= 0) begin
      tests++;
      if (gap !== exp_gap) begin
        fails++;
        $display("FAIL slot_gap: got %0d zero-grant cycles, want %0d", gap, exp_gap);
      end
    end
    len = 0;
    bad = 1'b0;
    while (grant !== 4'b0 && len < 200) begin
      if (grant !== exp_g || !radio_on || timeout) bad = 1'b1;
      len++;
      if (len == d) done[id] = 1'b1;
      else if (noise && len == 2) done[(id + 3) % 4] = 1'b1;
      @(negedge clk);
      done = '0;
    end
    model_last = id;
    exp_len = d < 50 ? d : 50;
    tests++;
    if (bad || len !== exp_len) begin
      fails++;
      $display("FAIL slot_hold: got len=%0d stable=%0d, want len=%0d stable=1", len, !bad, exp_len);
    end
    tests++;
    if (timeout !== (d > 50)) begin
      fails++;
      $display("FAIL slot_timeout: got timeout=%b, want %b (d=%0d)", timeout, d > 50, d);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (grant !== 4'b0 || grant_id !== 2'd0 || radio_on !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: got grant=%b id=%0d radio=%b busy=%b to=%b, want all 0",
               grant, grant_id, radio_on, busy, timeout);
    end
  endtask

  task automatic test_basic();
    int n;
    apply_reset();
    tx_enable = 1'b1;
    req = 4'b0001;
    @(negedge clk);
    tests++;
    if (radio_on !== 1'b1 || busy !== 1'b1 || grant !== 4'b0) begin
      fails++;
      $display("FAIL basic_warmup_entry: got radio=%b busy=%b grant=%b, want 1 1 0000", radio_on, busy, grant);
    end
    n = 0;
    while (grant == 4'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== 21) begin
      fails++;
      $display("FAIL basic_latency: got %0d cycles to grant, want 21", n);
    end
    slot(0, 5, -1, 1'b0);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (radio_on !== 1'b1) begin
      fails++;
      $display("FAIL basic_gap_radio: got radio=%b, want 1", radio_on);
    end
    @(negedge clk);
    tests++;
    if (radio_on !== 1'b0 || busy !== 1'b0 || grant !== 4'b0 || grant_id !== 2'd0) begin
      fails++;
      $display("FAIL basic_idle: got radio=%b busy=%b grant=%b id=%0d, want 0 0 0000 0", radio_on, busy, grant, grant_id);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    tx_enable = 1'b1;
    req = 4'b1111;
    slot(0, 5, -1, 1'b0);
    slot(1, 5, 3, 1'b0);
    slot(2, 5, 3, 1'b0);
    slot(3, 5, 3, 1'b0);
    slot(0, 5, 3, 1'b0);
  endtask

  task automatic test_timeout();
    apply_reset();
    tx_enable = 1'b1;
    req = 4'b0100;
    slot(2, 1000, -1, 1'b0);
    @(negedge clk);
    tests++;
    if (timeout !== 1'b0 || grant !== 4'b0) begin
      fails++;
      $display("FAIL timeout_width: got timeout=%b grant=%b one cycle later, want 0 0000", timeout, grant);
    end
    slot(2, 5, 2, 1'b0);
  endtask

  task automatic test_tx_drop_warmup();
    bit seen;
    apply_reset();
    tx_enable = 1'b1;
    req = 4'b0001;
    seen = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      seen |= (grant != 4'b0);
      @(negedge clk);
    end
    tx_enable = 1'b0;
    @(negedge clk);
    tests++;
    if (radio_on !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL drop_warmup_idle: got radio=%b busy=%b, want 0 0", radio_on, busy);
    end
    for (int i = 0; i < 30; i++) begin
      seen |= (grant != 4'b0) || radio_on;
      @(negedge clk);
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL drop_warmup_grant: got grant or radio activity=1, want 0");
    end
  endtask

  task automatic test_tx_drop_grant();
    int n;
    apply_reset();
    tx_enable = 1'b1;
    req = 4'b0001;
    n = 0;
    while (grant == 4'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    tx_enable = 1'b0;
    slot(0, 10, 0, 1'b0);
    repeat (3) @(negedge clk);
    tests++;
    if (radio_on !== 1'b0 || busy !== 1'b0 || grant !== 4'b0) begin
      fails++;
      $display("FAIL drop_grant_idle: got radio=%b busy=%b grant=%b, want 0 0 0000", radio_on, busy, grant);
    end
  endtask

  task automatic test_done_edges();
    apply_reset();
    tx_enable = 1'b1;
    req = 4'b0001;
    slot(0, 8, -1, 1'b1);
    slot(0, 50, 3, 1'b0);
  endtask

  task automatic test_async_reset();
    int n;
    apply_reset();
    tx_enable = 1'b1;
    req = 4'b1111;
    n = 0;
    while (grant == 4'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    tests++;
    if (grant !== 4'b0 || radio_on !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got grant=%b radio=%b busy=%b before next edge, want 0000 0 0", grant, radio_on, busy);
    end
    #1 reset = 1'b0;
    req = 4'b1010;
    model_last = 3;
    slot(1, 4, -1, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] mask;
    int d;
    apply_reset();
    tx_enable = 1'b1;
    for (int r = 0; r < 6; r++) begin
      mask = 4'($urandom_range(1, 15));
      req = mask;
      for (int s = 0; s < 4; s++) begin
        d = ($urandom_range(0, 5) == 0) ? $urandom_range(49, 52) : $urandom_range(1, 8);
        slot(next_id(mask), d, (r == 0 && s == 0) ? -1 : 3, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_tx_drop_warmup();
    test_tx_drop_grant();
    test_done_edges();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
